mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch port (IF) and data-memory port (DM).
- Two-level handshake: request held until acknowledge.
- Sits between the pipeline's fetch/MEM stages and the unified memory.
- Arbitration: fixed data-port priority plus an anti-starvation counter that guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive lost IF arbitrations after which IF wins; legal 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req_i  in  1  IF read request, held until if_ack_o.
- if_addr_i  in  ADDR_W  IF address.
- if_rdata_o  out  DATA_W  IF read data, valid only with if_ack_o.
- if_ack_o  out  1  one-cycle completion pulse.
- dm_req_i  in  1  DM request, held until dm_ack_o.
- dm_we_i  in  1  1=write, 0=read.
- dm_addr_i  in  ADDR_W  DM address.
- dm_wdata_i  in  DATA_W  DM write data.
- dm_be_i  in  DATA_W/8  DM byte enables.
- dm_rdata_o  out  DATA_W  DM read data, valid only with dm_ack_o.
- dm_ack_o  out  1  one-cycle completion pulse.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_be_o  out  DATA_W/8  memory byte enables; all ones for IF.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion pulse.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Single clock domain. Reset is synchronous active-high on clk.
- Reset values: state=IDLE, starve_cnt=0; mem_req_o, mem_we_o, if_ack_o, dm_ack_o, busy_o = 0; mem_addr_o, mem_wdata_o, mem_be_o = 0.
- FSM states: IDLE, GNT_IF, GNT_DM.
- IDLE arbitration, one decision per cycle:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant DM, unless starve_cnt==STARVE_MAX, then grant IF.
- Grant effects:
  - Granting moves the FSM to GNT_IF or GNT_DM.
  - The winner's address, we, wdata and be are latched into registered mem_* outputs.
  - mem_req_o rises on the next edge.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each IDLE cycle where both requests are high and DM wins.
  - Clears to 0 whenever IF is granted.
  - Otherwise holds.
- GNT_x states:
  - mem_req_o and the mem_* fields are held stable until mem_ack_i.
  - The cycle mem_ack_i=1: the granted port's ack is asserted combinationally in that same cycle, and its rdata = mem_rdata_i.
  - On the following edge: mem_req_o=0, return to IDLE.
  - The non-granted ack stays 0.
  - Write acks pulse identically; their rdata is don't-care.
- Latency:
  - Request first seen in IDLE at cycle N → mem_req_o high at N+1.
  - Zero-wait memory (mem_ack_i at N+1) → port ack at N+1.
  - One mandatory IDLE cycle between transactions, so the next grant is decided at N+2.
- Outside their ack cycle, if_rdata_o and dm_rdata_o are 0.
- mem_ack_i in IDLE (spurious or late) is ignored: no ack, no state change.
- A request dropped before its ack is a protocol violation. The arbiter still completes the granted transaction and pulses the ack.
- Reset mid-transaction:
  - The next edge forces IDLE with mem_req_o=0 and starve_cnt=0.
  - No ack is issued for the aborted transaction.
  - A subsequent mem_ack_i is ignored per the IDLE rule.
- Requests arriving while busy wait. Only the IDLE-cycle arbitration decides.

Test Plan:
- IF only, addr 0x0000_0040, memory acks 1 cycle after mem_req_o with 0x0000_0013 → mem_req_o at N+1 with mem_be_o=0xF; if_ack_o one pulse at N+2 with if_rdata_o=0x13; dm_ack_o never high.
- DM write, addr 0x100, wdata 0xDEADBEEF, be 0x3, zero-wait memory → mem_we_o=1, mem_wdata_o=0xDEADBEEF, mem_be_o=0x3 at N+1; dm_ack_o at N+1; busy_o low at N+2.
- Both requesting at once, STARVE_MAX=4 → DM granted at the same-cycle conflict; the bench reissues a new DM request in each IDLE cycle; IF granted on the 5th conflicting arbitration; starve_cnt returns to 0.
- rst asserted while in GNT_DM with mem_req_o high → next edge: mem_req_o=0, busy_o=0, no dm_ack_o; a mem_ack_i one cycle later produces no ack.
- mem_ack_i pulsed while IDLE with no requests → all acks stay 0 and the state stays IDLE; then an IF request is served normally.
- DM read with 3-cycle memory latency → mem_addr_o and mem_req_o held stable for 3 cycles; dm_ack_o with dm_rdata_o=mem_rdata_i exactly in the mem_ack_i cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction-fetch (IF)
// and data-memory (DM) ports: DM has priority, IF is guaranteed progress by a starve counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_ack_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_ack_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic                busy_o
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StGntIf, StGntDm} state_e;

    state_e                state_q, state_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        unique case (state_q)
            StIdle: begin
                // DM wins a conflict unless IF has already lost StarveMax times in a row.
                if (dm_req_i && (!if_req_i || starve_cnt_q != StarveMax)) begin
                    state_d     = StGntDm;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    mem_be_d    = dm_be_i;
                    if (if_req_i && starve_cnt_q != StarveMax) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (if_req_i) begin
                    state_d      = StGntIf;
                    starve_cnt_d = 4'd0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr_i;
                    mem_be_d     = '1;
                end
            end
            StGntIf, StGntDm: begin
                if (mem_ack_i) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            starve_cnt_q <= 4'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    // Port acks are combinational on mem_ack_i so zero-wait memory completes in one cycle.
    assign if_ack_o    = (state_q == StGntIf) && mem_ack_i;
    assign dm_ack_o    = (state_q == StGntDm) && mem_ack_i;
    assign if_rdata_o  = if_ack_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_ack_o ? mem_rdata_i : '0;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// request/latency traffic, all checked against a transaction-level grant model.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int lost   = 0;  // consecutive conflicts IF has lost (reference model)

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ack_o   (if_ack_o),
        .dm_req_i   (dm_req_i),
        .dm_we_i    (dm_we_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_be_i    (dm_be_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_ack_o   (dm_ack_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i),
        .busy_o     (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven; runs one whole transaction
    // with `lat` wait cycles before mem_ack_i, then leaves the bench in the next IDLE cycle.
    task automatic do_xact(input int lat, input logic [31:0] rd, output bit won_if);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [3:0]  eb;
        logic        ewe;
        if (if_req_i && dm_req_i) begin
            won_if = (lost == STARVE_MAX);
            lost   = won_if ? 0 : lost + 1;
        end else begin
            won_if = if_req_i;
        end
        if (won_if) lost = 0;
        ea  = won_if ? if_addr_i : dm_addr_i;
        ewe = won_if ? 1'b0 : dm_we_i;
        eb  = won_if ? 4'hF : dm_be_i;
        ewd = dm_wdata_i;
        #1;
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_mem_req", mem_req_o, 1'b0);
        tick();
        chk("gnt_mem_req", mem_req_o, 1'b1);
        chk("gnt_busy", busy_o, 1'b1);
        chk("gnt_addr", mem_addr_o, ea);
        chk("gnt_we", mem_we_o, ewe);
        chk("gnt_be", mem_be_o, eb);
        if (!won_if) chk("gnt_wdata", mem_wdata_o, ewd);
        for (int i = 0; i < lat; i++) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            #1;
            chk("wait_if_ack", if_ack_o, 1'b0);
            chk("wait_dm_ack", dm_ack_o, 1'b0);
            chk("wait_if_rdata", if_rdata_o, 32'h0);
            chk("wait_dm_rdata", dm_rdata_o, 32'h0);
            chk("wait_mem_req", mem_req_o, 1'b1);
            chk("wait_addr", mem_addr_o, ea);
            tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd;
        #1;
        chk("ack_if", if_ack_o, won_if);
        chk("ack_dm", dm_ack_o, !won_if);
        if (won_if) begin
            chk("ack_if_rdata", if_rdata_o, rd);
            chk("ack_dm_rdata_zero", dm_rdata_o, 32'h0);
        end else begin
            if (!ewe) chk("ack_dm_rdata", dm_rdata_o, rd);
            chk("ack_if_rdata_zero", if_rdata_o, 32'h0);
        end
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (won_if) if_req_i = 1'b0;
        else        dm_req_i = 1'b0;
        #1;
        chk("post_busy", busy_o, 1'b0);
        chk("post_mem_req", mem_req_o, 1'b0);
        chk("post_if_ack", if_ack_o, 1'b0);
        chk("post_dm_ack", dm_ack_o, 1'b0);
    endtask

    initial begin
        bit won_if;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;
        repeat (3) tick();
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_mem_be", mem_be_o, 4'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_if_ack", if_ack_o, 1'b0);
        chk("rst_dm_ack", dm_ack_o, 1'b0);
        rst = 1'b0;
        tick();

        // IF-only fetch, one wait cycle, returns 0x13.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        do_xact(1, 32'h0000_0013, won_if);
        chk("if_only_won", won_if, 1'b1);

        // DM write, zero-wait memory.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100;
        dm_wdata_i = 32'hDEAD_BEEF; dm_be_i = 4'h3;
        do_xact(0, 32'h0, won_if);

        // Sustained conflict: IF must win exactly on the 5th arbitration, then count restarts.
        for (int k = 1; k <= 6; k++) begin
            bit saw_if;
            if_req_i = 1'b1; if_addr_i = 32'h2000 + 32'(k);
            dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3000 + 32'(k); dm_be_i = 4'hF;
            do_xact(0, $urandom, won_if);
            saw_if = (k == 5);
            chk("starve_if_wins_5th", won_if, saw_if);
        end
        if_req_i = 1'b0;
        tick();

        // Reset while DM holds the memory.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h400; dm_be_i = 4'hF;
        tick();
        chk("rst_mid_gnt_req", mem_req_o, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_mid_mem_req", mem_req_o, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b0);
        chk("rst_mid_dm_ack", dm_ack_o, 1'b0);
        rst = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h55;
        lost = 0;
        #1;
        chk("late_ack_dm", dm_ack_o, 1'b0);
        chk("late_ack_if", if_ack_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        chk("late_ack_busy", busy_o, 1'b0);

        // Spurious ack in IDLE, then a normal IF fetch.
        mem_ack_i = 1'b1;
        #1;
        chk("spur_if_ack", if_ack_o, 1'b0);
        chk("spur_dm_ack", dm_ack_o, 1'b0);
        tick();
        mem_ack_i = 1'b0;
        chk("spur_busy", busy_o, 1'b0);
        if_req_i = 1'b1; if_addr_i = 32'h80;
        do_xact(0, 32'hCAFE_0001, won_if);

        // DM read with three wait cycles.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0A00; dm_be_i = 4'hF;
        do_xact(3, 32'h1234_5678, won_if);

        // Random traffic; a losing request stays asserted with its fields unchanged.
        for (int n = 0; n < 300; n++) begin
            if (!if_req_i && $urandom_range(0, 1) == 1) begin
                if_req_i = 1'b1; if_addr_i = $urandom;
            end
            if (!dm_req_i && $urandom_range(0, 1) == 1) begin
                dm_req_i = 1'b1; dm_we_i = 1'($urandom_range(0, 1));
                dm_addr_i = $urandom; dm_wdata_i = $urandom; dm_be_i = 4'($urandom_range(0, 15));
            end
            if (!if_req_i && !dm_req_i) begin
                mem_ack_i = 1'($urandom_range(0, 1));
                #1;
                chk("rnd_idle_if_ack", if_ack_o, 1'b0);
                chk("rnd_idle_dm_ack", dm_ack_o, 1'b0);
                tick();
                mem_ack_i = 1'b0;
                chk("rnd_idle_busy", busy_o, 1'b0);
            end else begin
                do_xact($urandom_range(0, 3), $urandom, won_if);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
